frame_buf_sched: RTL and testbench
==================================

// Module: frame_buf_sched
// PURPOSE
//  Schedules DDR3 bursts for the video frame buffer: shares the memory command port between
//  the ISP write FIFO and the display read FIFO. Generates burst addresses and manages triple
//  buffering so the display never reads a bank being written. Sits between the FIFO pair and
//  the DDR3 user interface, in the DDR 100 MHz domain.
// PARAMETERS
//  ADDR_W       29        DDR word address width
//  LEN_W        8         burst length width (words)
//  LVL_W        12        FIFO level width
//  RD_FIFO_DEPTH 2048     read FIFO depth (words)
//  RD_URGENT    256       read FIFO level below which reads take priority
//  BANK_OFFSET  2097152   word stride between the 3 frame banks (>= addr_max)
// PORTS
//  clk          in   1       DDR user clock; all logic on rising edge
//  reset        in   1       synchronous, active-high
//  init_done    in   1       DDR calibration complete; no commands before this is 1
//  wr_load      in   1       write frame sync (level, already in clk domain); rising edge = new frame
//  rd_load      in   1       read frame sync (level, already in clk domain); rising edge = new frame
//  addr_max     in   ADDR_W  words per frame
//  burst_len    in   LEN_W   words per burst (nonzero; divides addr_max)
//  wr_fifo_cnt  in   LVL_W   words held in write FIFO
//  rd_fifo_cnt  in   LVL_W   words held in read FIFO
//  cmd_valid    out  1       burst command valid
//  cmd_ready    in   1       controller accepts command when cmd_valid&cmd_ready
//  cmd_wr       out  1       1 = write burst, 0 = read burst
//  cmd_addr     out  ADDR_W  burst start address = bank*BANK_OFFSET + offset
//  cmd_len      out  LEN_W   burst length (= burst_len sampled at issue)
//  burst_done   in   1       1-cycle pulse: last data word of accepted burst transferred
//  wr_bank      out  2       bank being written (0..2)
//  rd_bank      out  2       bank being read (0..2)
//  frame_drop   out  1       1-cycle pulse: wr_load arrived before write frame completed
//  busy         out  1       1 while state != IDLE/ARB
// BEHAVIOUR
//  Reset: cmd_valid=0, cmd_wr=0, cmd_addr=0, cmd_len=0, wr_bank=0, rd_bank=2, frame_drop=0,
//   busy=0; wr_off=rd_off=0, done_bank=2, done_valid=0, wr_cmpl=0, pend_wl=pend_rl=0, last_grant=rd.
//  Edge detect: wl_rise/rl_rise from 1-cycle-delayed copies; set pend_wl/pend_rl (sticky).
//  FSM: IDLE -> ARB when init_done=1. ARB -> CMD on grant, else stay. CMD holds cmd_valid=1,
//   fields stable, until cmd_ready -> DATA (cmd_valid=0 next cycle). DATA -> ARB on burst_done.
//   init_done falling forces IDLE from any state, cmd_valid=0.
//  Pending loads applied only in ARB, before arbitration, same cycle (never mid-burst):
//   pend_wl: wr_off<=0; if wr_cmpl: done_bank<=wr_bank, done_valid<=1, wr_bank<=3-wr_bank-rd_bank;
//    else frame_drop pulse, wr_bank unchanged. wr_cmpl<=0. pend_wl<=0.
//   pend_rl: rd_off<=0; if done_valid rd_bank<=done_bank (uses done_bank updated this cycle).
//   Invariant wr_bank != rd_bank always; no grant in that ARB cycle (arbitrate next cycle).
//  Requests: wreq = wr_fifo_cnt >= burst_len; rreq = rd_fifo_cnt + burst_len <= RD_FIFO_DEPTH.
//  Grant: rreq & rd_fifo_cnt < RD_URGENT -> read; else both -> opposite of last_grant;
//   else the single requester. Grant registers cmd_wr, cmd_addr, cmd_len=burst_len, last_grant.
//  Offsets advance at cmd accept: off+burst_len >= addr_max -> off<=0 (write: wr_cmpl<=1);
//   else off<=off+burst_len. Sum computed ADDR_W+1 bits, no overflow.
//  Simultaneous wr/rd rise handled in same ARB cycle, write first. New edge during
//   CMD/DATA stays pending; repeated edges before ARB collapse to one.
// TESTING
//  Reset, init_done=0, both FIFOs ready -> cmd_valid stays 0, wr_bank=0, rd_bank=2.
//  addr_max=64,burst_len=16, wr_fifo_cnt=16 only -> write cmds addr 0,16,32,48,0; wr_cmpl set after 48.
//  Both requesting, rd_fifo_cnt=1000 -> grants alternate W,R,W,R; rd_fifo_cnt=100 -> reads only.
//  Full frame then wr_load rise -> wr_bank 0->1, done_bank=0; rd_load rise -> rd_bank=0; next wr_load -> wr_bank=2.
//  wr_load rise after 2 of 4 bursts -> frame_drop pulse, wr_bank unchanged, next addr 0.
//  wr_load rise while cmd_valid held with cmd_ready=0 -> cmd fields stable; load applied after burst_done.

Source files
------------

// File: rtl/frame_buf_sched_if.sv
// DDR3 burst command port between the frame buffer scheduler and the memory controller.
// The scheduler drives commands (master); the controller accepts them and reports completion (slave).
interface frame_buf_sched_if #(
  parameter int ADDR_W = 29,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              burst_done;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len,
    input  cmd_ready, burst_done
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
    output cmd_ready, burst_done
  );
endinterface

// File: rtl/frame_buf_sched.sv
// Triple-buffered DDR3 burst scheduler: arbitrates the ISP write FIFO against the display read
// FIFO and rotates frame banks so the display never reads the bank currently being written.
module frame_buf_sched #(
  parameter int ADDR_W        = 29,
  parameter int LEN_W         = 8,
  parameter int LVL_W         = 12,
  parameter int RD_FIFO_DEPTH = 2048,
  parameter int RD_URGENT     = 256,
  parameter int BANK_OFFSET   = 2097152
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_done,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic [ADDR_W-1:0] addr_max,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [LVL_W-1:0]  wr_fifo_cnt,
  input  logic [LVL_W-1:0]  rd_fifo_cnt,
  frame_buf_sched_if.master cmd,
  output logic [1:0]        wr_bank,
  output logic [1:0]        rd_bank,
  output logic              frame_drop,
  output logic              busy
);

  localparam int CW  = ((LVL_W > LEN_W) ? LVL_W : LEN_W) + 1;
  localparam int AW1 = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, ARB, CMD, DATA} state_t;

  state_t            state_q, state_d;
  logic              wl_d1_q, wl_d1_d, rl_d1_q, rl_d1_d;
  logic              pend_wl_q, pend_wl_d, pend_rl_q, pend_rl_d;
  logic [ADDR_W-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
  logic [1:0]        wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]        done_bank_q, done_bank_d;
  logic              done_valid_q, done_valid_d;
  logic              wr_cmpl_q, wr_cmpl_d;
  logic              last_wr_q, last_wr_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
  logic              frame_drop_q, frame_drop_d;

  logic              wl_rise, rl_rise;
  logic              wreq, rreq, urgent;
  logic [CW-1:0]     rd_need;
  logic              grant_wr;
  logic [1:0]        grant_bank;
  logic [ADDR_W-1:0] grant_base, grant_off;
  logic [ADDR_W-1:0] acc_off;
  logic [AW1-1:0]    off_sum;
  logic [ADDR_W-1:0] off_next;
  logic              frame_end;

  assign wl_rise = wr_load & ~wl_d1_q;
  assign rl_rise = rd_load & ~rl_d1_q;

  assign rd_need = CW'(rd_fifo_cnt) + CW'(burst_len);
  assign rreq    = rd_need <= CW'(RD_FIFO_DEPTH);
  assign wreq    = CW'(wr_fifo_cnt) >= CW'(burst_len);
  assign urgent  = rd_fifo_cnt < LVL_W'(RD_URGENT);

  // Urgent reads win outright; otherwise contending requesters take turns.
  always_comb begin
    grant_wr = 1'b0;
    if (rreq && urgent) begin
      grant_wr = 1'b0;
    end else if (wreq && rreq) begin
      grant_wr = ~last_wr_q;
    end else begin
      grant_wr = wreq;
    end
    grant_bank = grant_wr ? wr_bank_q : rd_bank_q;
    grant_off  = grant_wr ? wr_off_q : rd_off_q;
    case (grant_bank)
      2'd1:    grant_base = ADDR_W'(BANK_OFFSET);
      2'd2:    grant_base = ADDR_W'(2 * BANK_OFFSET);
      default: grant_base = '0;
    endcase
  end

  assign acc_off   = cmd_wr_q ? wr_off_q : rd_off_q;
  assign off_sum   = {1'b0, acc_off} + AW1'(cmd_len_q);
  assign frame_end = off_sum >= {1'b0, addr_max};
  assign off_next  = frame_end ? '0 : off_sum[ADDR_W-1:0];

  always_comb begin
    state_d      = state_q;
    wl_d1_d      = wr_load;
    rl_d1_d      = rd_load;
    pend_wl_d    = pend_wl_q | wl_rise;
    pend_rl_d    = pend_rl_q | rl_rise;
    wr_off_d     = wr_off_q;
    rd_off_d     = rd_off_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    done_bank_d  = done_bank_q;
    done_valid_d = done_valid_q;
    wr_cmpl_d    = wr_cmpl_q;
    last_wr_d    = last_wr_q;
    cmd_wr_d     = cmd_wr_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_len_d    = cmd_len_q;
    frame_drop_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (init_done) state_d = ARB;
      end
      ARB: begin
        // Frame loads take a whole ARB cycle; the read side sees the bank just retired by the write side.
        if (pend_wl_q || pend_rl_q) begin
          if (pend_wl_q) begin
            wr_off_d = '0;
            if (wr_cmpl_q) begin
              done_bank_d  = wr_bank_q;
              done_valid_d = 1'b1;
              wr_bank_d    = 2'd3 - wr_bank_q - rd_bank_q;
            end else begin
              frame_drop_d = 1'b1;
            end
            wr_cmpl_d = 1'b0;
            pend_wl_d = wl_rise;
          end
          if (pend_rl_q) begin
            rd_off_d = '0;
            if (done_valid_d) rd_bank_d = done_bank_d;
            pend_rl_d = rl_rise;
          end
        end else if (wreq || rreq) begin
          cmd_wr_d   = grant_wr;
          cmd_addr_d = grant_base + grant_off;
          cmd_len_d  = burst_len;
          last_wr_d  = grant_wr;
          state_d    = CMD;
        end
      end
      CMD: begin
        if (cmd.cmd_ready) begin
          if (cmd_wr_q) begin
            wr_off_d = off_next;
            if (frame_end) wr_cmpl_d = 1'b1;
          end else begin
            rd_off_d = off_next;
          end
          state_d = DATA;
        end
      end
      DATA: begin
        if (cmd.burst_done) state_d = ARB;
      end
      default: state_d = IDLE;
    endcase

    if (!init_done) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wl_d1_q      <= 1'b0;
      rl_d1_q      <= 1'b0;
      pend_wl_q    <= 1'b0;
      pend_rl_q    <= 1'b0;
      wr_off_q     <= '0;
      rd_off_q     <= '0;
      wr_bank_q    <= 2'd0;
      rd_bank_q    <= 2'd2;
      done_bank_q  <= 2'd2;
      done_valid_q <= 1'b0;
      wr_cmpl_q    <= 1'b0;
      last_wr_q    <= 1'b0;
      cmd_wr_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wl_d1_q      <= wl_d1_d;
      rl_d1_q      <= rl_d1_d;
      pend_wl_q    <= pend_wl_d;
      pend_rl_q    <= pend_rl_d;
      wr_off_q     <= wr_off_d;
      rd_off_q     <= rd_off_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      done_bank_q  <= done_bank_d;
      done_valid_q <= done_valid_d;
      wr_cmpl_q    <= wr_cmpl_d;
      last_wr_q    <= last_wr_d;
      cmd_wr_q     <= cmd_wr_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_len_q    <= cmd_len_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  assign cmd.cmd_valid = (state_q == CMD);
  assign cmd.cmd_wr    = cmd_wr_q;
  assign cmd.cmd_addr  = cmd_addr_q;
  assign cmd.cmd_len   = cmd_len_q;
  assign wr_bank       = wr_bank_q;
  assign rd_bank       = rd_bank_q;
  assign frame_drop    = frame_drop_q;
  assign busy          = (state_q == CMD) || (state_q == DATA);

endmodule

// File: tb/tb_frame_buf_sched.sv
// Randomized bench for frame_buf_sched: a frame-level reference model predicts every burst
// command and every dropped frame; a negedge monitor compares them against the DUT.
module tb_frame_buf_sched;
  localparam int ADDR_W        = 29;
  localparam int LEN_W         = 8;
  localparam int LVL_W         = 12;
  localparam int RD_FIFO_DEPTH = 2048;
  localparam int RD_URGENT     = 256;
  localparam int BANK_OFFSET   = 2097152;
  localparam int ITER          = 150;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [1:0]        wb;
    logic [1:0]        rb;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              init_done;
  logic              wr_load;
  logic              rd_load;
  logic [ADDR_W-1:0] addr_max;
  logic [LEN_W-1:0]  burst_len;
  logic [LVL_W-1:0]  wr_fifo_cnt;
  logic [LVL_W-1:0]  rd_fifo_cnt;
  logic [1:0]        wr_bank;
  logic [1:0]        rd_bank;
  logic              frame_drop;
  logic              busy;

  int   checks   = 0;
  int   failures = 0;
  bit   abort    = 1'b0;
  exp_t exp_q[$];
  int   drop_q[$];

  // Reference model state: frame offsets, bank roles and pending frame syncs.
  int m_wr_off, m_rd_off, m_wr_bank, m_rd_bank, m_done_bank;
  bit m_done_valid, m_wr_cmpl, m_last_wr, m_pend_wl, m_pend_rl;

  always #5 clk = ~clk;

  frame_buf_sched_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) cmd_if ();

  frame_buf_sched #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .LVL_W(LVL_W), .RD_FIFO_DEPTH(RD_FIFO_DEPTH),
    .RD_URGENT(RD_URGENT), .BANK_OFFSET(BANK_OFFSET)
  ) dut (
    .clk(clk), .reset(reset), .init_done(init_done), .wr_load(wr_load), .rd_load(rd_load),
    .addr_max(addr_max), .burst_len(burst_len), .wr_fifo_cnt(wr_fifo_cnt),
    .rd_fifo_cnt(rd_fifo_cnt), .cmd(cmd_if), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .frame_drop(frame_drop), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Apply pending frame syncs (write first), then choose the requester and predict its command.
  task automatic predictNext();
    int  len, amax, off, bank, nxt;
    bit  wreq, rreq, gw;
    exp_t e;
    len  = int'(burst_len);
    amax = int'(addr_max);
    if (m_pend_wl) begin
      m_wr_off = 0;
      if (m_wr_cmpl) begin
        m_done_bank  = m_wr_bank;
        m_done_valid = 1'b1;
        m_wr_bank    = 3 - m_wr_bank - m_rd_bank;
      end else begin
        drop_q.push_back(m_wr_bank);
      end
      m_wr_cmpl = 1'b0;
      m_pend_wl = 1'b0;
    end
    if (m_pend_rl) begin
      m_rd_off = 0;
      if (m_done_valid) m_rd_bank = m_done_bank;
      m_pend_rl = 1'b0;
    end
    wreq = int'(wr_fifo_cnt) >= len;
    rreq = int'(rd_fifo_cnt) + len <= RD_FIFO_DEPTH;
    if (rreq && int'(rd_fifo_cnt) < RD_URGENT) gw = 1'b0;
    else if (wreq && rreq)                     gw = !m_last_wr;
    else                                       gw = wreq;
    m_last_wr = gw;
    off  = gw ? m_wr_off : m_rd_off;
    bank = gw ? m_wr_bank : m_rd_bank;
    nxt  = (off + len >= amax) ? 0 : off + len;
    if (gw) begin
      m_wr_off = nxt;
      if (nxt == 0) m_wr_cmpl = 1'b1;
    end else begin
      m_rd_off = nxt;
    end
    e.wr   = gw;
    e.addr = ADDR_W'(bank * BANK_OFFSET + off);
    e.len  = LEN_W'(len);
    e.wb   = 2'(m_wr_bank);
    e.rb   = 2'(m_rd_bank);
    exp_q.push_back(e);
  endtask

  task automatic pulseLoads(input bit w, input bit r);
    wr_load = w;
    rd_load = r;
    @(posedge clk); #1;
    wr_load = 1'b0;
    rd_load = 1'b0;
    @(posedge clk); #1;
    if (w) m_pend_wl = 1'b1;
    if (r) m_pend_rl = 1'b1;
  endtask

  // One burst: new levels and optional frame syncs, release the DUT, stall, accept.
  task automatic applyStimulus(input bit first);
    int lens[3] = '{8, 16, 32};
    int len, n, k;
    len       = lens[$urandom_range(0, 2)];
    burst_len = LEN_W'(len);
    case ($urandom_range(0, 3))
      0: begin wr_fifo_cnt = LVL_W'($urandom_range(len, 300)); rd_fifo_cnt = 12'd2047; end
      1: begin wr_fifo_cnt = LVL_W'($urandom_range(0, 300)); rd_fifo_cnt = LVL_W'($urandom_range(0, 255)); end
      2: begin wr_fifo_cnt = LVL_W'($urandom_range(len, 300)); rd_fifo_cnt = LVL_W'($urandom_range(256, 1500)); end
      default: begin wr_fifo_cnt = LVL_W'($urandom_range(0, 300)); rd_fifo_cnt = LVL_W'($urandom_range(0, 2047)); end
    endcase
    if (int'(wr_fifo_cnt) < len && int'(rd_fifo_cnt) + len > RD_FIFO_DEPTH) wr_fifo_cnt = LVL_W'(len);
    if (!first && $urandom_range(0, 3) == 0)
      pulseLoads($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    predictNext();
    if (first) begin
      init_done = 1'b1;
    end else begin
      cmd_if.burst_done = 1'b1;
      @(posedge clk); #1;
      cmd_if.burst_done = 1'b0;
    end
    n = 0;
    while (!cmd_if.cmd_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_if.cmd_valid) begin
      checkOutput("cmd_timeout", 64'(cmd_if.cmd_valid), 64'd1);
      abort = 1'b1;
      return;
    end
    k = $urandom_range(0, 3);
    for (int j = 0; j < k; j++) begin
      if ($urandom_range(0, 5) == 0) pulseLoads($urandom_range(0, 1) == 1, 1'b1);
      else begin @(posedge clk); #1; end
    end
    cmd_if.cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_if.cmd_ready = 1'b0;
    k = $urandom_range(0, 2);
    for (int j = 0; j < k; j++) begin @(posedge clk); #1; end
  endtask

  // Monitor: every cycle a command is presented it must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t act;
    if (!reset) begin
      if (cmd_if.cmd_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_cmd", 64'(cmd_if.cmd_valid), 64'd0);
        end else begin
          act = {cmd_if.cmd_wr, cmd_if.cmd_addr, cmd_if.cmd_len, wr_bank, rd_bank};
          checkOutput("cmd", 64'(act), 64'(exp_q[0]));
          if (cmd_if.cmd_ready) void'(exp_q.pop_front());
        end
      end
      if (frame_drop) begin
        if (drop_q.size() == 0) checkOutput("unexpected_drop", 64'(frame_drop), 64'd0);
        else checkOutput("drop_bank", 64'(wr_bank), 64'(drop_q.pop_front()));
      end
    end
  end

  initial begin
    reset             = 1'b1;
    init_done         = 1'b0;
    wr_load           = 1'b0;
    rd_load           = 1'b0;
    addr_max          = ADDR_W'(64);
    burst_len         = LEN_W'(16);
    wr_fifo_cnt       = LVL_W'(100);
    rd_fifo_cnt       = LVL_W'(0);
    cmd_if.cmd_ready  = 1'b0;
    cmd_if.burst_done = 1'b0;
    m_wr_off = 0; m_rd_off = 0; m_wr_bank = 0; m_rd_bank = 2; m_done_bank = 2;
    m_done_valid = 1'b0; m_wr_cmpl = 1'b0; m_last_wr = 1'b0; m_pend_wl = 1'b0; m_pend_rl = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state",
      64'({cmd_if.cmd_valid, busy, frame_drop, wr_bank, rd_bank, cmd_if.cmd_wr, cmd_if.cmd_addr, cmd_if.cmd_len}),
      64'({1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 29'd0, 8'd0}));
    @(posedge clk); #1;
    for (int it = 0; it < ITER && !abort; it++) applyStimulus(it == 0);
    if (!abort) begin
      init_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("init_drop_idle", 64'({cmd_if.cmd_valid, busy}), 64'd0);
      checkOutput("cmds_drained", 64'(exp_q.size()), 64'd0);
      checkOutput("drops_drained", 64'(drop_q.size()), 64'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
